tmds_hdmi_encoder: RTL and testbench

Parametrised successor to the DVI 8b/10b channel encoder for the HDMI-capable TX path. It adds two output modes to the existing video and control coding: TERC4 data-island coding and video guard-band insertion. One instance drives each of the three TMDS lanes; the lane's identity is set by the CHANNEL parameter. It sits in the pclk domain, between the pixel/packet source and the 30-to-15 FIFO that feeds the OSERDES.

---
 rtl/tmds_pkg.sv | 26 ++
 rtl/tmds_qm_stage.sv | 38 +++
 rtl/tmds_hdmi_encoder.sv | 85 ++++++++
 tb/tb_tmds_hdmi_encoder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: mode encodings, fixed TMDS code tables and popcount helper for the HDMI lane encoder
package tmds_pkg;
  typedef enum logic [1:0] {
    MODE_VIDEO = 2'd0,
    MODE_CTRL  = 2'd1,
    MODE_TERC4 = 2'd2,
    MODE_GUARD = 2'd3
  } mode_t;
  localparam logic [9:0] CTRL_CODE [4] = '{
    10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
  };
  localparam logic [9:0] TERC4_CODE [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
  localparam logic [9:0] GUARD_RB = 10'b1011001100;
  localparam logic [9:0] GUARD_G  = 10'b0100110011;
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/tmds_qm_stage.sv
// tmds_qm_stage: stage-1 transition-minimised word register with ones/zeros count of q_m[7:0]
//   clk, rst : pixel clock, async active-high reset
//   din      : pixel byte
//   q_m      : registered 9-bit transition-minimised word (bit 8 = 1 for XOR chaining)
//   n1q, n0q : ones/zeros in registered q_m[7:0]
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  output logic [8:0] q_m,
  output logic [3:0] n1q,
  output logic [3:0] n0q
);
  logic [3:0] n1d;
  logic [3:0] n1q_c;
  logic [8:0] q_c;
  logic       xn;
  always_comb begin
    n1d = popcount8(din);
    xn = n1d > 4'd4 || (n1d == 4'd4 && !din[0]);
    q_c = {~xn, 8'b0};
    q_c[0] = din[0];
    // XNOR chaining is XOR chaining with every step inverted
    for (int i = 1; i < 8; i++) q_c[i] = q_c[i-1] ^ din[i] ^ xn;
    n1q_c = popcount8(q_c[7:0]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      q_m <= '0;
      n1q <= '0;
    end else begin
      q_m <= q_c;
      n1q <= n1q_c;
    end
  assign n0q = 4'd8 - n1q;
endmodule

// File: rtl/tmds_hdmi_encoder.sv
// tmds_hdmi_encoder: one TMDS lane encoder (video 8b/10b, control, TERC4, guard band), 2-cycle latency
//   clkin, rstin   : pixel clock, async active-high reset
//   din, de        : pixel byte and data enable (video when mode 0 and de)
//   c0, c1         : control bits
//   mode           : 0 video/control, 1 forced control, 2 TERC4, 3 guard band
//   aux            : TERC4 nibble
//   dout           : registered 10-bit symbol, bit 0 sent first
module tmds_hdmi_encoder
  import tmds_pkg::*;
#(
  parameter int CHANNEL    = 0,
  parameter int CNT_W      = 5,
  parameter int INVERT_OUT = 0
) (
  input  logic       clkin,
  input  logic       rstin,
  input  logic [7:0] din,
  input  logic       c0,
  input  logic       c1,
  input  logic       de,
  input  logic [1:0] mode,
  input  logic [3:0] aux,
  output logic [9:0] dout
);
  if (CHANNEL < 0 || CHANNEL > 2 || CNT_W < 5) begin : g_bad_param
    $error("tmds_hdmi_encoder: CHANNEL must be 0..2 and CNT_W >= 5");
  end
  localparam logic [9:0] GUARD = CHANNEL == 1 ? GUARD_G : GUARD_RB;
  localparam logic [9:0] INV_MASK = INVERT_OUT != 0 ? '1 : '0;
  localparam logic signed [CNT_W-1:0] TWO = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] ZERO = '0;
  logic [8:0] q_m;
  logic [3:0] n1q, n0q;
  logic [1:0] c_r;
  logic       de_r;
  mode_t      mode_r;
  logic [3:0] aux_r;
  logic signed [CNT_W-1:0] cnt, cnt_nx, d;
  logic       vid, bal, flip;
  logic [9:0] vsym, sym;
  tmds_qm_stage u_qm (
    .clk (clkin),
    .rst (rstin),
    .din (din),
    .q_m (q_m),
    .n1q (n1q),
    .n0q (n0q)
  );
  always_ff @(posedge clkin or posedge rstin)
    if (rstin) begin
      c_r <= '0;
      de_r <= 1'b0;
      mode_r <= MODE_VIDEO;
      aux_r <= '0;
    end else begin
      c_r <= {c1, c0};
      de_r <= de;
      mode_r <= mode_t'(mode);
      aux_r <= aux;
    end
  always_comb begin
    vid = mode_r == MODE_VIDEO && de_r;
    d = $signed(CNT_W'(n1q)) - $signed(CNT_W'(n0q));
    bal = cnt == ZERO || n1q == n0q;
    // invert when the word would push the running disparity further from zero
    flip = (cnt > ZERO && n1q > n0q) || (cnt < ZERO && n0q > n1q);
    vsym = bal ? {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}
               : {flip, q_m[8], flip ? ~q_m[7:0] : q_m[7:0]};
    cnt_nx = !vid ? ZERO
           : bal  ? (q_m[8] ? cnt + d : cnt - d)
           : flip ? cnt - d + (q_m[8] ? TWO : ZERO)
           :        cnt + d - (q_m[8] ? ZERO : TWO);
    sym = mode_r == MODE_TERC4 ? TERC4_CODE[aux_r]
        : mode_r == MODE_GUARD ? GUARD
        : vid ? vsym : CTRL_CODE[c_r];
  end
  always_ff @(posedge clkin or posedge rstin)
    if (rstin) begin
      dout <= '0;
      cnt <= ZERO;
    end else begin
      dout <= sym ^ INV_MASK;
      cnt <= cnt_nx;
    end
endmodule

// File: tb/tb_tmds_hdmi_encoder.sv
// tb_tmds_hdmi_encoder: table-driven and randomized self-check of three encoder lanes against a symbol-level model
module tb_tmds_hdmi_encoder;
  typedef struct packed {
    logic [1:0] mode;
    logic       de;
    logic [1:0] c;
    logic [7:0] din;
    logic [3:0] aux;
  } in_t;
  typedef struct {
    in_t        in;
    logic [9:0] exp;
    string      name;
  } vec_t;
  localparam logic [9:0] T_CTRL [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  localparam logic [9:0] T_TERC [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
  };
  localparam logic [9:0] T_GRB = 10'b1011001100;
  localparam logic [9:0] T_GG = 10'b0100110011;
  logic clkin = 1'b0;
  logic rstin = 1'b1;
  in_t  cur = '0;
  in_t  pend = '0;
  logic [9:0] dout_a, dout_b, dout_c;
  logic [9:0] exp_a, exp_b, exp_c;
  int   m_cnt = 0;
  logic last_vid = 1'b0;
  logic [7:0] last_din = '0;
  int   checks = 0;
  int   errors = 0;
  always #5 clkin = ~clkin;
  tmds_hdmi_encoder #(.CHANNEL(0), .CNT_W(5), .INVERT_OUT(0)) dut_a (
    .clkin(clkin), .rstin(rstin), .din(cur.din), .c0(cur.c[0]), .c1(cur.c[1]),
    .de(cur.de), .mode(cur.mode), .aux(cur.aux), .dout(dout_a));
  tmds_hdmi_encoder #(.CHANNEL(1), .CNT_W(5), .INVERT_OUT(0)) dut_b (
    .clkin(clkin), .rstin(rstin), .din(cur.din), .c0(cur.c[0]), .c1(cur.c[1]),
    .de(cur.de), .mode(cur.mode), .aux(cur.aux), .dout(dout_b));
  tmds_hdmi_encoder #(.CHANNEL(2), .CNT_W(6), .INVERT_OUT(1)) dut_c (
    .clkin(clkin), .rstin(rstin), .din(cur.din), .c0(cur.c[0]), .c1(cur.c[1]),
    .de(cur.de), .mode(cur.mode), .aux(cur.aux), .dout(dout_c));
  function automatic in_t mk(input logic [1:0] m, input logic e, input logic [1:0] c,
                             input logic [7:0] d, input logic [3:0] a);
    in_t r;
    r.mode = m;
    r.de = e;
    r.c = c;
    r.din = d;
    r.aux = a;
    return r;
  endfunction
  function automatic int ones(input logic [9:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 10; i++) n += int'(v[i]);
    return n;
  endfunction
  function automatic logic [9:0] video(input logic [7:0] d);
    logic [8:0] q;
    int n, k;
    logic xn;
    n = ones({2'b0, d});
    xn = n > 4 || (n == 4 && !d[0]);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : q[i-1] ^ d[i];
    q[8] = !xn;
    k = ones({2'b0, q[7:0]});
    if (m_cnt == 0 || k == 4) return q[8] ? {2'b01, q[7:0]} : {2'b10, ~q[7:0]};
    if ((m_cnt > 0) == (k > 4)) return {1'b1, q[8], ~q[7:0]};
    return {1'b0, q[8], q[7:0]};
  endfunction
  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ !s[8];
    return d;
  endfunction
  task automatic model_edge();
    logic [9:0] s;
    if (rstin) begin
      pend = '0;
      m_cnt = 0;
      exp_a = '0;
      exp_b = '0;
      exp_c = '0;
      last_vid = 1'b0;
      return;
    end
    last_vid = pend.mode == 2'd0 && pend.de;
    last_din = pend.din;
    s = pend.mode == 2'd2 ? T_TERC[pend.aux] : last_vid ? video(pend.din) : T_CTRL[pend.c];
    // running disparity is the accumulated ones-minus-zeros of emitted video symbols
    m_cnt = last_vid ? m_cnt + 2 * ones(s) - 10 : 0;
    exp_a = pend.mode == 2'd3 ? T_GRB : s;
    exp_b = pend.mode == 2'd3 ? T_GG : s;
    exp_c = ~(pend.mode == 2'd3 ? T_GRB : s);
    pend = cur;
  endtask
  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clkin);
    model_edge();
    #1;
    chk("lane0", dout_a, exp_a);
    chk("lane1", dout_b, exp_b);
    chk("lane2_inv", dout_c, exp_c);
    chk_i("cnt_lane0", int'(dut_a.cnt), m_cnt);
    chk_i("cnt_lane2", int'(dut_c.cnt), m_cnt);
    if (last_vid) begin
      chk("decode", {2'b0, decode(dout_a)}, {2'b0, last_din});
      chk_i("cnt_bound", int'(dut_a.cnt >= -5'sd8 && dut_a.cnt <= 5'sd8), 1);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    vec_t vecs[$];
    vec_t v;
    logic [9:0] dsym [3];
    int dcnt [3];
    dsym = '{10'b0100000000, 10'b1111111111, 10'b0100000000};
    dcnt = '{-8, 2, -6};
    for (int i = 0; i < 4; i++) begin
      v.in = mk(2'd0, 1'b0, 2'(i), 8'($urandom), 4'($urandom));
      v.exp = T_CTRL[i];
      v.name = "ctrl_de0";
      vecs.push_back(v);
      v.in = mk(2'd1, 1'b1, 2'(i), 8'($urandom), 4'($urandom));
      v.name = "ctrl_forced";
      vecs.push_back(v);
    end
    for (int i = 0; i < 16; i++) begin
      v.in = mk(2'd2, 1'($urandom), 2'($urandom), 8'($urandom), 4'(i));
      v.exp = T_TERC[i];
      v.name = "terc4";
      vecs.push_back(v);
    end
    v.in = mk(2'd3, 1'b1, 2'($urandom), 8'($urandom), 4'($urandom));
    v.exp = T_GRB;
    v.name = "guard_lane0";
    vecs.push_back(v);
    for (int i = 0; i < 3; i++) begin
      cur = mk(2'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), 4'($urandom));
      step();
      chk("reset_hold", dout_a, 10'h000);
    end
    rstin = 1'b0;
    cur = mk(2'd0, 1'b0, 2'd0, 8'h00, 4'h0);
    step();
    step();
    chk("post_reset_ctrl", dout_a, 10'b1101010100);
    for (int i = 0; i < 4; i++) begin
      cur = i < 3 ? mk(2'd0, 1'b1, 2'd0, 8'h00, 4'h0) : mk(2'd0, 1'b0, 2'd0, 8'h00, 4'h0);
      step();
      if (i >= 1) begin
        chk("disp_sym", dout_a, dsym[i-1]);
        chk_i("disp_cnt", int'(dut_a.cnt), dcnt[i-1]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cur = i == 0 || i == 2 ? mk(2'd0, 1'b1, 2'd0, 8'h00, 4'h0) : mk(2'd1, 1'b1, 2'd1, 8'h00, 4'h0);
      step();
    end
    chk("switch_clears_cnt", dout_a, 10'b0100000000);
    for (int i = 0; i <= vecs.size(); i++) begin
      cur = i < vecs.size() ? vecs[i].in : mk(2'd0, 1'b0, 2'd0, 8'h00, 4'h0);
      step();
      if (i >= 1) begin
        chk(vecs[i-1].name, dout_a, vecs[i-1].exp);
        if (vecs[i-1].in.mode == 2'd2) chk_i("terc4_cnt", int'(dut_a.cnt), 0);
        if (vecs[i-1].in.mode == 2'd3) begin
          chk("guard_lane1", dout_b, 10'b0100110011);
          chk("guard_lane2_inv", dout_c, ~10'b1011001100);
        end
      end
    end
    for (int i = 0; i < 10000; i++) begin
      cur = mk(2'd0, 1'b1, 2'($urandom), 8'($urandom), 4'($urandom));
      step();
      if (i == 5000) begin
        #2 rstin = 1'b1;
        #1;
        chk("midstream_reset_dout", dout_a, 10'h000);
        chk_i("midstream_reset_cnt", int'(dut_a.cnt), 0);
        step();
        rstin = 1'b0;
      end
    end
    for (int i = 0; i < 2000; i++) begin
      cur = mk(2'($urandom), 1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 4'($urandom));
      step();
    end
    cur = mk(2'd0, 1'b0, 2'd0, 8'h00, 4'h0);
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
